// File: rtl/twiddle_collect_pkg.sv
// Shared sizing and helpers for the twiddle collector: word width, lane/group
// geometry and lane slicing of the packed input beat.
package twiddle_collect_pkg;
    localparam int nb       = 9;
    localparam int LANES    = 4;
    localparam int GROUPS   = 8;
    localparam int DEPTH    = LANES * GROUPS;
    localparam int AW       = $clog2(DEPTH);
    localparam int GW       = $clog2(GROUPS);
    localparam int LW       = $clog2(LANES);
    localparam int SIGN_BIT = nb - 1;
    localparam int BUSW     = nb * LANES;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

    function automatic logic [nb-1:0] lane_slice(input logic [BUSW-1:0] bus, input int k);
        return bus[nb*k +: nb];
    endfunction
endpackage

// File: rtl/twiddle_collect_if.sv
// Beat input, indexed read port and frame status of the twiddle collector.
interface twiddle_collect_if;
    import twiddle_collect_pkg::*;

    logic            start;
    logic            ivalid;
    logic [BUSW-1:0] ir;
    logic [BUSW-1:0] ii;
    logic            rreq;
    logic [AW-1:0]   raddr;
    logic            rconj;
    logic [nb-1:0]   orr;
    logic [nb-1:0]   ori;
    logic            rvalid;
    logic            done;
    logic            err;
    logic [GW-1:0]   wptr;

    modport master (
        output start, ivalid, ir, ii, rreq, raddr, rconj,
        input  orr, ori, rvalid, done, err, wptr
    );

    modport slave (
        input  start, ivalid, ir, ii, rreq, raddr, rconj,
        output orr, ori, rvalid, done, err, wptr
    );
endinterface

// File: rtl/twiddle_collect_bank.sv
// 32-entry complex twiddle store: 4-lane write at a group base address and one
// registered read port with optional sign flip of the imaginary part.
module twiddle_bank
    import twiddle_collect_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    input  logic            we,
    input  logic [AW-1:0]   wbase,
    input  logic [BUSW-1:0] wr,
    input  logic [BUSW-1:0] wi,
    input  logic            rreq,
    input  logic [AW-1:0]   raddr,
    input  logic            rconj,
    output logic [nb-1:0]   orr,
    output logic [nb-1:0]   ori,
    output logic            rvalid
);
    logic [nb-1:0] mem_r [DEPTH];
    logic [nb-1:0] mem_i [DEPTH];
    logic [nb-1:0] conj_mask;

    assign conj_mask = {rconj, {SIGN_BIT{1'b0}}};

    // Read and write share the edge, so a colliding read sees the old entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
                mem_i[i] <= '0;
            end
            orr    <= '0;
            ori    <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rreq;
            if (rreq) begin
                orr <= mem_r[raddr];
                ori <= mem_i[raddr] ^ conj_mask;
            end
            if (we) begin
                for (int k = 0; k < LANES; k++) begin
                    mem_r[wbase + AW'(k)] <= lane_slice(wr, k);
                    mem_i[wbase + AW'(k)] <= lane_slice(wi, k);
                end
            end
        end
    end
endmodule

// File: rtl/twiddle_collect.sv
// Twiddle stream receiver: tracks the group write pointer and frame status and
// feeds beats into the twiddle bank.
//
//   state | meaning
//   ------+---------------------------------------------
//   FILL  | frame incomplete, beats are written
//   FULL  | frame captured, further beats raise ERR
module twiddle_collect
    import twiddle_collect_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    twiddle_collect_if.slave bus
);
    fill_state_t   state;
    logic [GW-1:0] wptr;
    logic          err;
    logic          we;
    logic [AW-1:0] wbase;

    assign we    = bus.ivalid && !bus.start && (state == FILL);
    assign wbase = {wptr, {LW{1'b0}}};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= FILL;
            wptr  <= '0;
            err   <= 1'b0;
        end else if (bus.start) begin
            state <= FILL;
            wptr  <= '0;
            err   <= 1'b0;
        end else if (bus.ivalid) begin
            case (state)
                FILL: begin
                    if (wptr == GW'(GROUPS - 1)) begin
                        wptr  <= '0;
                        state <= FULL;
                    end else begin
                        wptr <= wptr + GW'(1);
                    end
                end
                FULL:    err <= 1'b1;
                default: state <= FILL;
            endcase
        end
    end

    assign bus.done = (state == FULL);
    assign bus.err  = err;
    assign bus.wptr = wptr;

    twiddle_bank u_bank (
        .CLK    (CLK),
        .RST    (RST),
        .we     (we),
        .wbase  (wbase),
        .wr     (bus.ir),
        .wi     (bus.ii),
        .rreq   (bus.rreq),
        .raddr  (bus.raddr),
        .rconj  (bus.rconj),
        .orr    (bus.orr),
        .ori    (bus.ori),
        .rvalid (bus.rvalid)
    );
endmodule

// File: tb/tb_twiddle_collect.sv
// Bench for twiddle_collect: behavioural frame/bank model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_twiddle_collect;
    import twiddle_collect_pkg::*;

    logic CLK;
    logic RST;
    twiddle_collect_if bus ();

    twiddle_collect dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total;
    int passed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: frame captured as a plain array, beat counter as an int.
    logic [nb-1:0] m_r [32];
    logic [nb-1:0] m_i [32];
    logic [nb-1:0] m_orr, m_ori;
    logic          m_rvalid, m_done, m_err;
    int            m_wp;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) begin
                m_r[i] = '0;
                m_i[i] = '0;
            end
            m_orr = '0; m_ori = '0; m_rvalid = 1'b0;
            m_done = 1'b0; m_err = 1'b0; m_wp = 0;
        end else begin
            if (bus.rreq) begin
                m_orr = m_r[bus.raddr];
                m_ori = m_i[bus.raddr] ^ (bus.rconj ? 9'h100 : 9'h000);
            end
            m_rvalid = bus.rreq;
            if (bus.start) begin
                m_wp = 0; m_done = 1'b0; m_err = 1'b0;
            end else if (bus.ivalid) begin
                if (m_done) m_err = 1'b1;
                else begin
                    for (int k = 0; k < 4; k++) begin
                        m_r[m_wp*4 + k] = bus.ir[9*k +: 9];
                        m_i[m_wp*4 + k] = bus.ii[9*k +: 9];
                    end
                    m_wp++;
                    if (m_wp == 8) begin
                        m_wp = 0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("orr", 32'(bus.orr), 32'(m_orr));
        chk("ori", 32'(bus.ori), 32'(m_ori));
        chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("wptr", 32'(bus.wptr), 32'(m_wp));
    end

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic beat(input logic [35:0] r, input logic [35:0] i);
        bus.ivalid = 1'b1; bus.ir = r; bus.ii = i;
        cyc();
        bus.ivalid = 1'b0;
    endtask

    task automatic rd(input int addr, input logic conj);
        bus.rreq = 1'b1; bus.raddr = 5'(addr); bus.rconj = conj;
        cyc();
        bus.rreq = 1'b0; bus.rconj = 1'b0;
    endtask

    task automatic strt();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    function automatic logic [35:0] pat(input int base, input int g);
        logic [35:0] v;
        for (int k = 0; k < 4; k++) v[9*k +: 9] = 9'(base + g*4 + k);
        return v;
    endfunction

    function automatic logic [35:0] rnd36();
        logic [35:0] v;
        v = {4'($urandom), $urandom};
        return v;
    endfunction

    logic [35:0]   tr, ti;
    logic [nb-1:0] old9;

    initial begin
        total = 0; passed = 0;
        RST = 1'b1;
        bus.start = 0; bus.ivalid = 0; bus.ir = '0; bus.ii = '0;
        bus.rreq = 0; bus.raddr = '0; bus.rconj = 0;
        #1 RST = 1'b0;
        #1;
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_wptr", 32'(bus.wptr), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_orr", 32'(bus.orr), 0);
        cyc(); cyc();
        RST = 1'b1;
        cyc();

        // Full frame with counting pattern
        for (int g = 0; g < 8; g++) beat(pat(9'h080, g), pat(0, g));
        chk("fill_done", 32'(bus.done), 1);
        chk("fill_wptr", 32'(bus.wptr), 0);
        chk("model_r13", 32'(m_r[13]), 32'h08D);
        rd(13, 1'b0);
        chk("rd13_orr", 32'(bus.orr), 32'h08D);
        chk("rd13_ori", 32'(bus.ori), 32'h00D);
        chk("rd13_rvalid", 32'(bus.rvalid), 1);

        // Overflow beat
        beat(rnd36(), rnd36());
        chk("ovf_err", 32'(bus.err), 1);
        chk("ovf_done", 32'(bus.done), 1);
        rd(0, 1'b0);
        chk("ovf_rd0_orr", 32'(bus.orr), 32'h080);
        chk("ovf_rd0_ori", 32'(bus.ori), 32'h000);

        // Conjugation
        strt();
        chk("start_err", 32'(bus.err), 0);
        tr = rnd36(); ti = rnd36(); ti[8:0] = 9'h000;
        beat(tr, ti);
        tr = rnd36(); ti = rnd36(); tr[8:0] = 9'b001111011; ti[8:0] = 9'b101110010;
        beat(tr, ti);
        rd(4, 1'b1);
        chk("conj4_orr", 32'(bus.orr), 32'h07B);
        chk("conj4_ori", 32'(bus.ori), 32'h072);
        rd(0, 1'b1);
        chk("conj0_ori", 32'(bus.ori), 32'h100);

        // START colliding with beat 3
        strt();
        for (int g = 0; g < 3; g++) beat(rnd36(), rnd36());
        bus.start = 1'b1;
        beat(rnd36(), rnd36());
        bus.start = 1'b0;
        chk("coll_wptr", 32'(bus.wptr), 0);
        chk("coll_done", 32'(bus.done), 0);
        chk("coll_err", 32'(bus.err), 0);
        for (int g = 0; g < 8; g++) beat(rnd36(), rnd36());
        chk("refill_done", 32'(bus.done), 1);

        // Read-before-write on entry 9 (group 2, lane 1)
        strt();
        beat(rnd36(), rnd36());
        beat(rnd36(), rnd36());
        old9 = m_r[9];
        tr = rnd36(); tr[17:9] = 9'h155;
        bus.rreq = 1'b1; bus.raddr = 5'd9;
        beat(tr, rnd36());
        bus.rreq = 1'b0;
        chk("rbw_old", 32'(bus.orr), 32'(old9));
        rd(9, 1'b0);
        chk("rbw_new", 32'(bus.orr), 32'h155);

        // Asynchronous reset mid-frame
        strt();
        for (int g = 0; g < 4; g++) beat(rnd36(), rnd36());
        bus.rreq = 1'b1; bus.raddr = 5'd1;
        beat(rnd36(), rnd36());
        bus.rreq = 1'b0;
        #1 RST = 1'b0;
        #1;
        chk("arst_wptr", 32'(bus.wptr), 0);
        chk("arst_rvalid", 32'(bus.rvalid), 0);
        chk("arst_orr", 32'(bus.orr), 0);
        chk("arst_ori", 32'(bus.ori), 0);
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_err", 32'(bus.err), 0);
        cyc();
        RST = 1'b1;
        cyc();
        for (int a = 0; a < 32; a++) begin
            rd(a, 1'b0);
            chk("arst_bank_r", 32'(bus.orr), 0);
            chk("arst_bank_i", 32'(bus.ori), 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.start  = ($urandom_range(0, 39) == 0);
            bus.ivalid = ($urandom_range(0, 9) < 6);
            bus.ir     = rnd36();
            bus.ii     = rnd36();
            bus.rreq   = ($urandom_range(0, 1) == 1);
            bus.raddr  = 5'($urandom);
            bus.rconj  = 1'($urandom);
            cyc();
        end
        bus.start = 0; bus.ivalid = 0; bus.rreq = 0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
